// File: rtl/wwblock_sprite_fetch_pkg.sv
// rtl/wwblock_sprite_fetch_pkg.sv - shared types and defaults for the sprite fetch slice
package wwblock_pkg;

    typedef logic [3:0] pal_idx_t;

    localparam int       SPR_W_DEF      = 64;
    localparam int       SPR_H_DEF      = 64;
    localparam pal_idx_t TRANSP_IDX_DEF = 4'd0;

    typedef enum logic [0:0] {
        FS_IDLE  = 1'b0,
        FS_FLASH = 1'b1
    } flash_state_t;

    // Width of a counter/index that must hold values 0..v-1, never narrower than one bit.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/wwblock_sprite_fetch_if.sv
// rtl/wwblock_sprite_fetch_if.sv - raster, placement, sprite ROM and pixel output bundle
interface wwblock_sprite_fetch_if
    import wwblock_pkg::*;
#(
    parameter int AW = 14
);
    logic [9:0]    draw_x;
    logic [9:0]    draw_y;
    logic [9:0]    pos_x;
    logic [9:0]    pos_y;
    logic          flip_h;
    logic [AW-1:0] rom_addr;
    pal_idx_t      rom_q;
    pal_idx_t      pix_index;
    logic          pix_valid;

    // Raster/placement source, sprite ROM and pixel consumer side.
    modport master (
        output draw_x, draw_y, pos_x, pos_y, flip_h, rom_q,
        input  rom_addr, pix_index, pix_valid
    );

    // The fetch block itself.
    modport slave (
        input  draw_x, draw_y, pos_x, pos_y, flip_h, rom_q,
        output rom_addr, pix_index, pix_valid
    );
endinterface

// File: rtl/wwblock_sprite_fetch_anim_ctrl.sv
// rtl/wwblock_sprite_fetch_anim_ctrl.sv - animation frame divider and hit-flash blink FSM
module wwblock_anim_ctrl
    import wwblock_pkg::*;
#(
    parameter int  NUM_FRAMES   = 4,
    parameter int  FRAME_DIV    = 6,
    parameter int  FLASH_FRAMES = 30,
    localparam int FW           = clog2_min1(NUM_FRAMES)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          frame_start,
    input  logic          anim_en,
    input  logic          hit,
    output logic [FW-1:0] anim_frame,
    output logic          blank_out
);

    localparam int DW = clog2_min1(FRAME_DIV);
    // At least 3 bits so the blink phase bit [2] always exists.
    localparam int CW = ($clog2(FLASH_FRAMES + 1) > 3) ? $clog2(FLASH_FRAMES + 1) : 3;

    localparam logic [0:0] ST_IDLE  = 1'(FS_IDLE);
    localparam logic [0:0] ST_FLASH = 1'(FS_FLASH);

    logic [DW-1:0] divider;
    logic [0:0]    state;
    logic [CW-1:0] flash_cnt;

    // Frame divider and animation frame step; only moves on frame_start so no mid-frame tearing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            divider    <= '0;
            anim_frame <= '0;
        end else if (frame_start && anim_en) begin
            if (divider == DW'(FRAME_DIV - 1)) begin
                divider    <= '0;
                anim_frame <= (anim_frame == FW'(NUM_FRAMES - 1)) ? '0 : anim_frame + 1'b1;
            end else begin
                divider <= divider + 1'b1;
            end
        end
    end

    // Hit-flash FSM; a hit always reloads and suppresses that cycle's decrement.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            flash_cnt <= '0;
        end else if (hit) begin
            state     <= ST_FLASH;
            flash_cnt <= CW'(FLASH_FRAMES);
        end else if (state == ST_FLASH && frame_start) begin
            if (flash_cnt == CW'(1)) begin
                state     <= ST_IDLE;
                flash_cnt <= '0;
            end else begin
                flash_cnt <= flash_cnt - 1'b1;
            end
        end
    end

    // Counter bit 2 toggles every 4 frames, giving the 4-hidden/4-shown blink.
    assign blank_out = (state == ST_FLASH) && flash_cnt[2];

endmodule

// File: rtl/wwblock_sprite_fetch.sv
// rtl/wwblock_sprite_fetch.sv - sprite ROM address pipeline and opaque-pixel flag
module wwblock_sprite_fetch
    import wwblock_pkg::*;
#(
    parameter int       SPR_W        = SPR_W_DEF,
    parameter int       SPR_H        = SPR_H_DEF,
    parameter int       NUM_FRAMES   = 4,
    parameter int       FRAME_DIV    = 6,
    parameter int       FLASH_FRAMES = 30,
    parameter pal_idx_t TRANSP_IDX   = TRANSP_IDX_DEF,
    localparam int      AW           = $clog2(SPR_W * SPR_H * NUM_FRAMES),
    localparam int      FW           = clog2_min1(NUM_FRAMES)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   frame_start,
    input  logic                   anim_en,
    input  logic                   hit,
    output logic [FW-1:0]          anim_frame,
    wwblock_sprite_fetch_if.slave  bus
);

    localparam int XB = $clog2(SPR_W);
    localparam int YB = $clog2(SPR_H);

    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic               in_box;
    logic [XB-1:0]      lx;
    logic [AW-1:0]      addr;
    logic               box_d1;
    logic               blank_out;

    wwblock_anim_ctrl #(
        .NUM_FRAMES  (NUM_FRAMES),
        .FRAME_DIV   (FRAME_DIV),
        .FLASH_FRAMES(FLASH_FRAMES)
    ) u_anim_ctrl (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_start(frame_start),
        .anim_en    (anim_en),
        .hit        (hit),
        .anim_frame (anim_frame),
        .blank_out  (blank_out)
    );

    // Signed offsets keep a sprite clipped at the screen edge from wrapping onto the far side.
    assign dx = $signed({1'b0, bus.draw_x}) - $signed({1'b0, bus.pos_x});
    assign dy = $signed({1'b0, bus.draw_y}) - $signed({1'b0, bus.pos_y});

    assign in_box = !dx[10] && ({1'b0, dx[9:0]} < 11'(SPR_W)) &&
                    !dy[10] && ({1'b0, dy[9:0]} < 11'(SPR_H));

    // SPR_W is a power of two, so SPR_W-1-dx over the sprite span is just the inverted low bits.
    assign lx = bus.flip_h ? ~dx[XB-1:0] : dx[XB-1:0];

    assign addr = AW'(anim_frame) * AW'(SPR_W * SPR_H) + AW'(dy[YB-1:0]) * AW'(SPR_W) + AW'(lx);

    // Stage 1: present the ROM address, parked at 0 outside the sprite box.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.rom_addr <= '0;
            box_d1       <= 1'b0;
        end else begin
            bus.rom_addr <= in_box ? addr : '0;
            box_d1       <= in_box;
        end
    end

    // Stage 2: capture the ROM colour and decide opacity, hiding the sprite during flash blanking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.pix_index <= '0;
            bus.pix_valid <= 1'b0;
        end else begin
            bus.pix_index <= bus.rom_q;
            bus.pix_valid <= box_d1 && (bus.rom_q != TRANSP_IDX) && !blank_out;
        end
    end

endmodule

// File: tb/tb_wwblock_sprite_fetch.sv
// tb/tb_wwblock_sprite_fetch.sv - directed scoreboard bench for wwblock_sprite_fetch
module tb_wwblock_sprite_fetch;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       frame_start;
    logic       anim_en;
    logic       hit;
    logic [1:0] anim_frame;

    wwblock_sprite_fetch_if #(.AW(14)) bus ();

    wwblock_sprite_fetch dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_start(frame_start),
        .anim_en    (anim_en),
        .hit        (hit),
        .anim_frame (anim_frame),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Asynchronous sprite ROM: colour is the low address nibble xor 5, so address 5 is transparent.
    always_comb bus.rom_q = bus.rom_addr[3:0] ^ 4'h5;

    typedef struct packed {
        logic [3:0] idx;
        logic       v;
    } pix_t;

    pix_t exp_q[$];

    int vectors = 0;
    int miscompares = 0;

    int gx, gy, gpx, gpy;
    bit gfl;

    int m_div, m_frame, m_cnt;
    bit m_flash;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_div = 0; m_frame = 0; m_cnt = 0; m_flash = 0;
        exp_q.delete();
    endtask

    task automatic model_edge(input bit fs, input bit ae, input bit ht);
        if (fs && ae) begin
            if (m_div == 5) begin
                m_div = 0;
                m_frame = (m_frame == 3) ? 0 : m_frame + 1;
            end else begin
                m_div++;
            end
        end
        if (ht) begin
            m_flash = 1; m_cnt = 30;
        end else if (m_flash && fs) begin
            if (m_cnt == 1) begin
                m_flash = 0; m_cnt = 0;
            end else begin
                m_cnt--;
            end
        end
    endtask

    task automatic step(input bit fs, input bit ae, input bit ht);
        int   dx, dy, ea, ei;
        bit   box, blank;
        pix_t e;
        @(negedge clk);
        bus.draw_x = 10'(gx); bus.draw_y = 10'(gy);
        bus.pos_x = 10'(gpx); bus.pos_y = 10'(gpy); bus.flip_h = gfl;
        frame_start = fs; anim_en = ae; hit = ht;
        dx = gx - gpx; dy = gy - gpy;
        box = (dx >= 0) && (dx < 64) && (dy >= 0) && (dy < 64);
        ea = box ? (m_frame * 4096 + dy * 64 + (gfl ? 63 - dx : dx)) : 0;
        @(posedge clk);
        model_edge(fs, ae, ht);
        #1;
        chk("rom_addr", 32'(bus.rom_addr), 32'(ea));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pix_index", 32'(bus.pix_index), 32'(e.idx));
            chk("pix_valid", 32'(bus.pix_valid), 32'(e.v));
        end
        chk("anim_frame", 32'(anim_frame), 32'(m_frame));
        blank = m_flash && m_cnt[2];
        ei = (ea & 15) ^ 5;
        e.idx = 4'(ei);
        e.v = box && (ei != 0) && !blank;
        exp_q.push_back(e);
    endtask

    task automatic at(input int x, input int y);
        gx = x; gy = y;
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rom_addr"}, 32'(bus.rom_addr), 32'd0);
        chk({tag, "_pix_index"}, 32'(bus.pix_index), 32'd0);
        chk({tag, "_pix_valid"}, 32'(bus.pix_valid), 32'd0);
        chk({tag, "_anim_frame"}, 32'(anim_frame), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; frame_start = 1'b0; anim_en = 1'b0; hit = 1'b0;
        gx = 100; gy = 50; gpx = 100; gpy = 50; gfl = 1'b0;
        bus.draw_x = 10'd100; bus.draw_y = 10'd50;
        bus.pos_x = 10'd100; bus.pos_y = 10'd50; bus.flip_h = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Box origin, edges, transparency and flip.
        at(100, 50); at(101, 50); at(105, 50); at(102, 50);
        at(163, 50); at(164, 50); at(100, 113); at(100, 114); at(99, 50); at(100, 49);
        gfl = 1'b1; at(100, 50); at(163, 50); at(110, 60);
        gfl = 1'b0;

        // Screen-edge clipping must not wrap.
        gpx = 600; at(5, 50); at(639, 50); at(600, 80);
        gpx = 0; at(639, 50); at(0, 50); at(63, 113);
        gpx = 100; at(100, 50);

        // Animation: 6 pulses advance one frame, hold with anim_en low, wrap after 24.
        gx = 100; gy = 50;
        repeat (6) step(1'b1, 1'b1, 1'b0);
        chk("anim_frame_after6", 32'(anim_frame), 32'd1);
        at(100, 50); at(101, 51);
        chk("rom_addr_frame1", 32'(bus.rom_addr), 32'd4096 + 32'd64 + 32'd1);
        gx = 100; gy = 50;
        repeat (3) step(1'b1, 1'b0, 1'b0);
        repeat (18) step(1'b1, 1'b1, 1'b0);
        chk("anim_frame_wrap", 32'(anim_frame), 32'd0);
        at(100, 50);

        // Hit-flash blink sequence until the flash expires.
        gx = 100; gy = 50;
        step(1'b0, 1'b0, 1'b1);
        repeat (31) step(1'b1, 1'b0, 1'b0);
        at(100, 50); at(100, 50);

        // Hit coinciding with frame_start reloads without decrementing.
        step(1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        repeat (6) step(1'b1, 1'b0, 1'b0);

        // Reset while flashing and mid-line.
        step(1'b0, 1'b0, 1'b1);
        at(100, 50);
        @(negedge clk);
        reset_n = 1'b0; frame_start = 1'b0; hit = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        at(100, 50); at(102, 50); at(105, 50); at(164, 50); at(100, 50);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
